// File: rtl/hilo_div.sv
// Multi-cycle 32/32 restoring divider producing {remainder, quotient} for HI/LO.
// Define HILO_DIV_SIGNED_EN to honour signed_div_i (DIV); otherwise every divide is DIVU.
module hilo_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        annul_i,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_BYZERO = 2'd1,
      ST_ON     = 2'd2,
      ST_END    = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dividend_q, dividend_d;   // shifts out dividend bits, shifts in quotient bits
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] rem_q, rem_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;

   logic [33:0] trial;
   logic [31:0] op1_mag, op2_mag;
   logic [31:0] quo_fix, rem_fix;

`ifdef HILO_DIV_SIGNED_EN
   logic neg_quo_q, neg_quo_d;
   logic neg_rem_q, neg_rem_d;
   logic op1_neg, op2_neg;

   assign op1_neg = signed_div_i & opdata1_i[31];
   assign op2_neg = signed_div_i & opdata2_i[31];
   assign op1_mag = op1_neg ? (~opdata1_i + 32'd1) : opdata1_i;
   assign op2_mag = op2_neg ? (~opdata2_i + 32'd1) : opdata2_i;
   assign quo_fix = neg_quo_q ? (~dividend_q + 32'd1) : dividend_q;
   assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
`else
   logic sign_unused;

   assign sign_unused = signed_div_i;
   assign op1_mag     = opdata1_i;
   assign op2_mag     = opdata2_i;
   assign quo_fix     = dividend_q;
   assign rem_fix     = rem_q;
`endif

   // Partial remainder stays below the divisor, so {rem, bit} never exceeds 33 bits.
   assign trial = {1'b0, rem_q, dividend_q[31]} - {2'b00, divisor_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      result_d   = result_q;
      ready_d    = ready_q;
`ifdef HILO_DIV_SIGNED_EN
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
`endif

      case (state_q)
         ST_FREE: begin
            ready_d  = 1'b0;
            result_d = 64'd0;
            cnt_d    = 6'd0;
            if (start_i && !annul_i) begin
               dividend_d = op1_mag;
               divisor_d  = op2_mag;
               rem_d      = 32'd0;
`ifdef HILO_DIV_SIGNED_EN
               neg_quo_d  = op1_neg ^ op2_neg;
               neg_rem_d  = op1_neg;
`endif
               state_d    = (opdata2_i == 32'd0) ? ST_BYZERO : ST_ON;
            end
         end

         ST_BYZERO: begin
            ready_d  = 1'b0;
            result_d = 64'd0;
            cnt_d    = 6'd0;
            state_d  = annul_i ? ST_FREE : ST_END;
         end

         ST_ON: begin
            if (annul_i) begin
               state_d  = ST_FREE;
               ready_d  = 1'b0;
               result_d = 64'd0;
               cnt_d    = 6'd0;
            end else if (cnt_q == 6'd32) begin
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
               state_d  = ST_END;
            end else begin
               if (!trial[33]) begin
                  rem_d      = trial[31:0];
                  dividend_d = {dividend_q[30:0], 1'b1};
               end else begin
                  rem_d      = {rem_q[30:0], dividend_q[31]};
                  dividend_d = {dividend_q[30:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
            end
         end

         ST_END: begin
            if (start_i) begin
               ready_d = 1'b1;
            end else begin
               state_d  = ST_FREE;
               ready_d  = 1'b0;
               result_d = 64'd0;
            end
         end

         default: state_d = ST_FREE;
      endcase

      busy_d = (state_d == ST_BYZERO) || (state_d == ST_ON);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FREE;
         cnt_q      <= 6'd0;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
         rem_q      <= 32'd0;
         result_q   <= 64'd0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef HILO_DIV_SIGNED_EN
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
`ifdef HILO_DIV_SIGNED_EN
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
`endif
      end
   end

   assign result_o = result_q;
   assign ready_o  = ready_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_hilo_div.sv
// Directed bench for hilo_div: latency, results, by-zero, annul and reset behaviour.
// Expected values follow the HILO_DIV_SIGNED_EN setting of the build.
module tb_hilo_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        annul_i;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   hilo_div dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s = %h", tag, got);
      end
   endtask

   // Full handshake: accept, wait (bounded) for ready, hold in END, then release.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp_res, input int exp_lat);
      int n;
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = sgn;
      start_i      = 1'b1;
      tick();
      check({tag, "_busy_on"}, 64'(busy_o), 64'd1);
      // operands must be ignored once accepted
      opdata1_i    = ~a;
      opdata2_i    = 32'h0000_1234;
      signed_div_i = ~sgn;
      n = 1;
      while (!ready_o && n < 60) begin
         tick();
         n++;
      end
      check({tag, "_latency"}, 64'(n - 1), 64'(exp_lat));
      check({tag, "_result"}, result_o, exp_res);
      check({tag, "_busy_off"}, 64'(busy_o), 64'd0);
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      check({tag, "_end_hold_rdy"}, 64'(ready_o), 64'd1);
      check({tag, "_end_hold_res"}, result_o, exp_res);
      start_i = 1'b0;
      tick();
      check({tag, "_free_rdy"}, 64'(ready_o), 64'd0);
      check({tag, "_free_res"}, result_o, 64'd0);
   endtask

   logic [63:0] exp_neg7, exp_ovf;
   logic        rdy_seen;

   initial begin
`ifdef HILO_DIV_SIGNED_EN
      exp_neg7 = 64'hFFFFFFFF_FFFFFFFD;
      exp_ovf  = 64'h00000000_80000000;
`else
      exp_neg7 = 64'h00000001_7FFFFFFC;
      exp_ovf  = 64'h80000000_00000000;
`endif
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
      opdata1_i = 32'd0; opdata2_i = 32'd0;
      tick();
      tick();
      check("rst_result", result_o, 64'd0);
      check("rst_ready", 64'(ready_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      rst = 1'b0;
      tick();

      run_div("u100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33);
      run_div("s_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, exp_neg7, 33);
      run_div("byzero", 32'd5, 32'd0, 1'b0, 64'd0, 2);
      run_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, exp_ovf, 33);
      run_div("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'h00000000_00000001, 33);

      // annul during ON
      opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      annul_i = 1'b1;
      start_i = 1'b0;
      tick();
      annul_i = 1'b0;
      check("annul_busy", 64'(busy_o), 64'd0);
      check("annul_result", result_o, 64'd0);
      rdy_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         rdy_seen |= ready_o;
      end
      check("annul_no_ready", 64'(rdy_seen), 64'd0);
      run_div("u9_3", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33);

      // annul in FREE blocks acceptance
      start_i = 1'b1; annul_i = 1'b1;
      tick();
      check("annul_free_busy", 64'(busy_o), 64'd0);
      start_i = 1'b0; annul_i = 1'b0;
      tick();

      // reset mid-ON
      opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("midon_busy", 64'(busy_o), 64'd1);
      rst = 1'b1;
      tick();
      check("midrst_busy", 64'(busy_o), 64'd0);
      check("midrst_ready", 64'(ready_o), 64'd0);
      check("midrst_result", result_o, 64'd0);
      // request with rst asserted is dropped
      tick();
      check("rst_prio_busy", 64'(busy_o), 64'd0);
      rst = 1'b0; start_i = 1'b0;
      tick();

      // start dropped mid-ON: completes, END exits on the next edge
      opdata1_i = 32'd50; opdata2_i = 32'd6; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 32; i++) tick();
      check("drop_busy_c33", 64'(busy_o), 64'd1);
      tick();
      check("drop_ready", 64'(ready_o), 64'd1);
      check("drop_result", result_o, 64'h00000002_00000008);
      tick();
      check("drop_exit_ready", 64'(ready_o), 64'd0);
      check("drop_exit_result", result_o, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
